inst_loader: RTL and testbench

//   Boot/program loader sitting between the host interface and the instruction SRAM, upstream of BNNCtrl.

---
 rtl/inst_loader_if.sv | 30 +++
 rtl/inst_loader.sv | 140 ++++++++++++++
 tb/tb_inst_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Host program stream, instruction SRAM port and BNNCtrl control/status bundle for inst_loader.
// slave: the loader itself; master: the surrounding host / SRAM / BNNCtrl environment.
interface inst_loader_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
);
   logic              host_start;
   logic [ADDR_W-1:0] host_len_m1;
   logic              host_valid;
   logic [DATA_W-1:0] host_data;
   logic              host_ready;
   logic [ADDR_W+1:0] ctrl_sram_in;
   logic [ADDR_W+1:0] sram_ctrl;
   logic [DATA_W-1:0] sram_wdata;
   logic              ctrl_rst;
   logic              ctrl_pause;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output host_start, host_len_m1, host_valid, host_data, ctrl_sram_in,
      input  host_ready, sram_ctrl, sram_wdata, ctrl_rst, ctrl_pause, busy, done, err
   );

   modport slave (
      input  host_start, host_len_m1, host_valid, host_data, ctrl_sram_in,
      output host_ready, sram_ctrl, sram_wdata, ctrl_rst, ctrl_pause, busy, done, err
   );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: streams a host program into instruction SRAM from address 0, then releases BNNCtrl.
// Optional INST_LOADER_CHECKSUM_EN: trailing XOR checksum word verified before release.
module inst_loader #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   inst_loader_if.slave  bus
);
   localparam logic [ADDR_W+1:0] SRAM_IDLE = {2'b11, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHECK = 3'd2,
      S_ERR   = 3'd3,
`endif
      S_RUN   = 3'd4
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_len_m1;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W+1:0] r_sram_ctrl;
   logic [DATA_W-1:0] r_sram_wdata;
   logic              r_host_ready;
   logic              r_ctrl_rst;
   logic              r_ctrl_pause;
   logic              r_busy;
   logic              r_done;
`ifdef INST_LOADER_CHECKSUM_EN
   logic              r_err;
   logic [DATA_W-1:0] r_csum;
`endif

   logic w_hs;
   logic w_last;
   logic w_go_load;
   logic w_loader_owns;

   assign w_hs      = bus.host_valid & r_host_ready;
   assign w_last    = (r_count == r_len_m1);
   // busy marks exactly LOAD/CHECK, the only states where a new start is ignored
   assign w_go_load = bus.host_start & ~r_busy;
   // the final program write lands in the first RUN cycle, so the loader keeps the port for it
   assign w_loader_owns = (r_state != S_RUN) | ~r_sram_ctrl[ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_len_m1     <= '0;
         r_count      <= '0;
         r_sram_ctrl  <= SRAM_IDLE;
         r_sram_wdata <= '0;
         r_host_ready <= 1'b0;
         r_ctrl_rst   <= 1'b1;
         r_ctrl_pause <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         r_err        <= 1'b0;
         r_csum       <= '0;
`endif
      end else begin
         r_sram_ctrl  <= SRAM_IDLE;
         r_sram_wdata <= '0;
         if (w_go_load) begin
            r_state      <= S_LOAD;
            r_len_m1     <= bus.host_len_m1;
            r_count      <= '0;
            r_host_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_ctrl_rst   <= 1'b1;
            r_ctrl_pause <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            r_err        <= 1'b0;
            r_csum       <= '0;
`endif
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (w_hs) begin
                     r_sram_ctrl  <= {2'b00, r_count};
                     r_sram_wdata <= bus.host_data;
                     r_count      <= r_count + ADDR_W'(1);
`ifdef INST_LOADER_CHECKSUM_EN
                     r_csum       <= r_csum ^ bus.host_data;
                     if (w_last) r_state <= S_CHECK;
`else
                     if (w_last) begin
                        r_state      <= S_RUN;
                        r_host_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_ctrl_pause <= 1'b0;
                     end
`endif
                  end
               end
`ifdef INST_LOADER_CHECKSUM_EN
               S_CHECK: begin
                  // checksum word is consumed but never written to SRAM
                  if (w_hs) begin
                     r_host_ready <= 1'b0;
                     r_busy       <= 1'b0;
                     if (bus.host_data == r_csum) begin
                        r_state      <= S_RUN;
                        r_done       <= 1'b1;
                        r_ctrl_pause <= 1'b0;
                     end else begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                     end
                  end
               end
`endif
               S_RUN: r_ctrl_rst <= 1'b0;
               default: begin
               end
            endcase
         end
      end
   end

   assign bus.host_ready = r_host_ready;
   assign bus.sram_ctrl  = w_loader_owns ? r_sram_ctrl : bus.ctrl_sram_in;
   assign bus.sram_wdata = r_sram_wdata;
   assign bus.ctrl_rst   = r_ctrl_rst;
   assign bus.ctrl_pause = r_ctrl_pause;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
`ifdef INST_LOADER_CHECKSUM_EN
   assign bus.err        = r_err;
`else
   assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of program loads plus hand sequences for reload, reset and checksum.
// SRAM writes are checked against a queue of expected {addr,data} pushed at each host handshake.
module tb_inst_loader;
   localparam int unsigned AW = 11;
   localparam int unsigned DW = 16;
`ifdef INST_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam logic [AW+1:0] IDLE_CTRL = 13'h1800;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   inst_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   typedef struct {
      logic [AW-1:0] len_m1;
      logic [DW-1:0] w [4];
      bit            gap;
      logic          exp_done;
      logic          exp_err;
   } vec_t;

   vec_t              vecs [4];
   int                n_checks = 0;
   int                n_fail   = 0;
   logic [AW+DW-1:0]  exp_q [$];
   logic [AW-1:0]     exp_addr = '0;
   logic [DW-1:0]     mem [2**AW];
   logic [AW+DW-1:0]  mon_e;
   logic [DW-1:0]     cs;
   bit                mon_en = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] len);
      bus.host_start  = 1'b1;
      bus.host_len_m1 = len;
      exp_addr        = '0;
      cs              = '0;
      cycle();
      bus.host_start  = 1'b0;
   endtask

   task automatic send_word(input logic [DW-1:0] d, input bit wr);
      int t = 0;
      bus.host_valid = 1'b1;
      bus.host_data  = d;
      while (!bus.host_ready && t < 50) begin
         cycle();
         t++;
      end
      if (!bus.host_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: host_ready 0 for 50 cycles, required 1");
      end else if (wr) begin
         exp_q.push_back({exp_addr, d});
         exp_addr = exp_addr + 1'b1;
         cs       = cs ^ d;
      end
      cycle();
      bus.host_valid = 1'b0;
   endtask

   // Every loader write seen on the SRAM port must match the next expected handshake
   always @(negedge clk) begin
      if (mon_en && bus.sram_ctrl[AW] == 1'b0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     bus.sram_ctrl[AW-1:0], bus.sram_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_wen",  32'(bus.sram_ctrl[AW+1]), 32'(0));
            chk("wr_addr", 32'(bus.sram_ctrl[AW-1:0]), 32'(mon_e[AW+DW-1:DW]));
            chk("wr_data", 32'(bus.sram_wdata), 32'(mon_e[DW-1:0]));
            mem[bus.sram_ctrl[AW-1:0]] = bus.sram_wdata;
         end
      end
   end

   task automatic check_run_entry(input string tag);
      chk({tag, "_done"},  32'(bus.done), 32'(1));
      chk({tag, "_rst1"},  32'(bus.ctrl_rst), 32'(1));
      chk({tag, "_pause"}, 32'(bus.ctrl_pause), 32'(0));
      chk({tag, "_busy"},  32'(bus.busy), 32'(0));
      chk({tag, "_rdy"},   32'(bus.host_ready), 32'(0));
      chk({tag, "_err"},   32'(bus.err), 32'(0));
      cycle();
      chk({tag, "_rst0"},  32'(bus.ctrl_rst), 32'(0));
      chk({tag, "_qempty"}, 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].len_m1 = 11'd3; vecs[0].w = '{16'h0801, 16'h1000, 16'h2001, 16'h0000};
      vecs[0].gap = 1'b0; vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;
      vecs[1].len_m1 = 11'd3; vecs[1].w = '{16'h0801, 16'h1000, 16'h2001, 16'h0000};
      vecs[1].gap = 1'b1; vecs[1].exp_done = 1'b1; vecs[1].exp_err = 1'b0;
      vecs[2].len_m1 = 11'd1; vecs[2].w = '{16'h0003, 16'h0005, 16'h0000, 16'h0000};
      vecs[2].gap = 1'b0; vecs[2].exp_done = 1'b1; vecs[2].exp_err = 1'b0;
      vecs[3].len_m1 = 11'd0; vecs[3].w = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
      vecs[3].gap = 1'b1; vecs[3].exp_done = 1'b1; vecs[3].exp_err = 1'b0;

      rst = 1'b1;
      bus.host_start = 1'b0; bus.host_len_m1 = '0; bus.host_valid = 1'b0; bus.host_data = '0;
      bus.ctrl_sram_in = IDLE_CTRL;
      repeat (3) cycle();
      chk("rst_sram_ctrl", 32'(bus.sram_ctrl), 32'(IDLE_CTRL));
      chk("rst_wdata",     32'(bus.sram_wdata), 32'(0));
      chk("rst_ready",     32'(bus.host_ready), 32'(0));
      chk("rst_ctrl_rst",  32'(bus.ctrl_rst), 32'(1));
      chk("rst_pause",     32'(bus.ctrl_pause), 32'(1));
      chk("rst_busy",      32'(bus.busy), 32'(0));
      chk("rst_done",      32'(bus.done), 32'(0));
      chk("rst_err",       32'(bus.err), 32'(0));
      rst = 1'b0;
      bus.host_valid = 1'b1;
      cycle();
      cycle();
      chk("idle_ignores_valid", 32'(bus.host_ready), 32'(0));
      bus.host_valid = 1'b0;

      for (int v = 0; v < 4; v++) begin
         start_load(vecs[v].len_m1);
         chk("load_busy",  32'(bus.busy), 32'(1));
         chk("load_ready", 32'(bus.host_ready), 32'(1));
         chk("load_ctrl_rst", 32'(bus.ctrl_rst), 32'(1));
         chk("load_done",  32'(bus.done), 32'(0));
         for (int i = 0; i <= int'(vecs[v].len_m1); i++) begin
            send_word(vecs[v].w[i], 1'b1);
            if (vecs[v].gap && i < int'(vecs[v].len_m1)) begin
               cycle();
               chk("gap_cen", 32'(bus.sram_ctrl[AW]), 32'(1));
            end
         end
         if (CSUM) send_word(cs, 1'b0);
         chk("vec_done", 32'(bus.done), 32'(vecs[v].exp_done));
         chk("vec_err",  32'(bus.err), 32'(vecs[v].exp_err));
         check_run_entry("vec");
         for (int i = 0; i <= int'(vecs[v].len_m1); i++)
            chk("vec_mem", 32'(mem[i]), 32'(vecs[v].w[i]));
      end

      // RUN pass-through, then reload hands the port back to the loader
      mon_en = 1'b0;
      bus.ctrl_sram_in = 13'h1805;
      #1 chk("pass_1805", 32'(bus.sram_ctrl), 32'h1805);
      bus.ctrl_sram_in = 13'h0007;
      #1 chk("pass_0007", 32'(bus.sram_ctrl), 32'h0007);
      start_load(11'd1);
      chk("reload_mux",      32'(bus.sram_ctrl), 32'(IDLE_CTRL));
      chk("reload_ctrl_rst", 32'(bus.ctrl_rst), 32'(1));
      chk("reload_pause",    32'(bus.ctrl_pause), 32'(1));
      chk("reload_busy",     32'(bus.busy), 32'(1));
      chk("reload_done",     32'(bus.done), 32'(0));
      bus.ctrl_sram_in = IDLE_CTRL;
      mon_en = 1'b1;
      send_word(16'hA0A0, 1'b1);
      send_word(16'h0B0B, 1'b1);
      if (CSUM) send_word(cs, 1'b0);
      check_run_entry("reload");
      chk("reload_mem0", 32'(mem[0]), 32'hA0A0);
      chk("reload_mem1", 32'(mem[1]), 32'h0B0B);
      chk("reload_mem2", 32'(mem[2]), 32'h2001);
      chk("reload_mem3", 32'(mem[3]), 32'h0000);

      // host_start during LOAD must not restart or relatch the length
      start_load(11'd1);
      send_word(16'h1111, 1'b1);
      bus.host_start = 1'b1; bus.host_len_m1 = 11'd5;
      cycle();
      bus.host_start = 1'b0;
      chk("start_in_load_busy", 32'(bus.busy), 32'(1));
      send_word(16'h2222, 1'b1);
      if (CSUM) send_word(cs, 1'b0);
      check_run_entry("start_in_load");

      // synchronous reset in the middle of a 4-word load
      start_load(11'd3);
      send_word(16'h3333, 1'b1);
      send_word(16'h4444, 1'b1);
      rst = 1'b1;
      bus.host_valid = 1'b1; bus.host_data = 16'hDEAD;
      cycle();
      chk("midrst_ready",   32'(bus.host_ready), 32'(0));
      chk("midrst_ctrlrst", 32'(bus.ctrl_rst), 32'(1));
      chk("midrst_busy",    32'(bus.busy), 32'(0));
      chk("midrst_sram",    32'(bus.sram_ctrl), 32'(IDLE_CTRL));
      rst = 1'b0;
      repeat (4) cycle();
      chk("midrst_idle_ready", 32'(bus.host_ready), 32'(0));
      chk("midrst_done",       32'(bus.done), 32'(0));
      bus.host_valid = 1'b0;
      chk("midrst_qempty", 32'(exp_q.size()), 32'(0));
      chk("midrst_mem2",   32'(mem[2]), 32'h2001);

`ifdef INST_LOADER_CHECKSUM_EN
      start_load(11'd1);
      send_word(16'h0003, 1'b1);
      send_word(16'h0005, 1'b1);
      send_word(16'h0007, 1'b0);
      chk("csum_bad_err",     32'(bus.err), 32'(1));
      chk("csum_bad_ctrlrst", 32'(bus.ctrl_rst), 32'(1));
      chk("csum_bad_pause",   32'(bus.ctrl_pause), 32'(1));
      chk("csum_bad_done",    32'(bus.done), 32'(0));
      chk("csum_bad_ready",   32'(bus.host_ready), 32'(0));
      cycle();
      chk("csum_bad_hold_err", 32'(bus.err), 32'(1));
      chk("csum_bad_hold_rst", 32'(bus.ctrl_rst), 32'(1));
      start_load(11'd1);
      chk("csum_retry_err",  32'(bus.err), 32'(0));
      chk("csum_retry_busy", 32'(bus.busy), 32'(1));
      send_word(16'h0003, 1'b1);
      send_word(16'h0005, 1'b1);
      send_word(16'h0006, 1'b0);
      check_run_entry("csum_good");
`endif

      // full-SRAM load ending at the top address
      start_load(11'h7FF);
      for (int i = 0; i < 2**AW; i++) send_word(16'(i * 7 + 1), 1'b1);
      if (CSUM) send_word(cs, 1'b0);
      check_run_entry("full");
      chk("full_mem_top", 32'(mem[2**AW-1]), 32'(16'((2**AW - 1) * 7 + 1)));
      chk("full_mem_0",   32'(mem[0]), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
